gate_array_delayed: RTL and testbench
=====================================

Name: gate_array_delayed

Overview:
- Parametrised, clocked successor to the fixed dual 4-input gate package models in the 74LSxx library.
- Provides CHANNELS independent gates of INPUTS inputs each, with a run-time selectable logic function.
- Propagation delay is an integer number of clock cycles; optionally it models inertial delay, where short pulses are swallowed.
- Used as the synthesizable, cycle-accurate replacement for the `#DELAY` primitive models in board-level emulation designs.

Parameters:
- CHANNELS, 2, number of independent gates (≥1).
- INPUTS, 4, inputs per gate (≥2).
- DELAY_CYCLES, 2, propagation delay in clk cycles (≥1).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- mode  input  3  gate function: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR (odd parity), 5 XNOR; 6 and 7 are reserved and treated as AND.
- a  input  CHANNELS*INPUTS  gate inputs; channel i uses a[i*INPUTS +: INPUTS].
- y  output  CHANNELS  delayed gate outputs.
- y_valid  output  1  high once the delay line holds post-reset samples only.
- edge_pulse  output  CHANNELS  one-cycle pulse in the cycle y[i] changes.

Behaviour:
- Reset (reset_n low, asynchronous): y=0, edge_pulse=0, y_valid=0; all delay stages and counters clear to 0.
- f_i = mode-selected function of channel i's inputs. f_i is combinational and sampled at each rising edge.
- mode is sampled together with a. A mode change therefore propagates with the same latency as data, and no output glitch occurs beyond the new function value.
- Transport delay (default):
  - Per channel, a shift register of DELAY_CYCLES stages; stage0 <= f_i, stage k <= stage k-1.
  - y[i] = last stage.
  - A value sampled at edge t appears on y after edge t+DELAY_CYCLES-1.
  - Every pulse of any width, including 1 cycle, is reproduced exactly.
- y_valid:
  - Saturating counter of edges since reset deassertion.
  - Goes high after the DELAY_CYCLES-th edge and stays high until the next reset.
  - Before it goes high, y shows reset zeros.
- edge_pulse[i]:
  - Registered; high for exactly one cycle, aligned with the cycle in which y[i] holds its new value.
  - Suppressed while y_valid is low.
- Channels are fully independent; simultaneous changes on all channels are handled in the same cycle.
- Reset mid-operation discards all in-flight samples. Behaviour after release is identical to power-up.
- DELAY_CYCLES=1: y is f registered once.

Optional Feature:
- Macro: GATE_ARRAY_INERTIAL_EN.
- When defined, the shift register is replaced per channel by a counter of width $clog2(DELAY_CYCLES)+1 and the y register:
  - At each edge, if f_i == y[i]: cnt <= 0.
  - Else, if cnt == DELAY_CYCLES-1: y[i] <= f_i and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Net effect: a new level must be present on DELAY_CYCLES consecutive sampling edges to propagate. Latency for a stable change equals the transport case. Shorter pulses never reach y.
  - With DELAY_CYCLES=1 this is identical to transport.
- y_valid and edge_pulse rules are unchanged.
- When the macro is undefined, pure transport delay applies and no counter logic is present.

Decomposition:
- Package gate_array_pkg holds:
  - mode encoding localparams (MODE_AND … MODE_XNOR);
  - function gate_eval(mode, vector) returning 1 bit.
- Sub-module gate_delay_channel:
  - One channel's delay line or inertial filter plus its edge_pulse register.
  - Instantiated CHANNELS times in a generate loop.
  - The top level holds the y_valid counter and input slicing.

Test Plan:
- Defaults, mode=0. Hold a=8'hFF from edge 5, then a=8'h7F from edge 10 → y=2'b11 after edge 6; y=2'b01 after edge 11; edge_pulse=2'b11 in one cycle, then 2'b10 in one cycle.
- Mode sweep on channel 0 with inputs 4'b0110 → AND 0, NAND 1, OR 1, NOR 0, XOR 0, XNOR 1, mode 7 gives 0. Each result appears DELAY_CYCLES cycles after the mode change.
- One-cycle pulse of a[3:0]=4'hF in AND mode, DELAY_CYCLES=3:
  - Transport: y[0] shows a one-cycle pulse after edge t+2.
  - With GATE_ARRAY_INERTIAL_EN: no pulse, and edge_pulse stays 0.
- Inertial, DELAY_CYCLES=3. Hold f=1 for 2 edges → y stays 0. Hold for 3 edges → y=1 after the 3rd edge.
- Assert reset_n low mid-stream with a pulse in flight → y, edge_pulse and y_valid go 0 immediately, without waiting for a clock edge. After release, y_valid rises on the DELAY_CYCLES-th edge and the pre-reset pulse never appears.
- CHANNELS=8, INPUTS=3, random a/mode for 10k cycles → y matches a golden model: f delayed by DELAY_CYCLES, with inertial filtering when the macro is defined.

Source files
------------

// File: rtl/gate_array_pkg.sv
// Purpose : shared mode encodings and the combinational gate function for gate_array_delayed.
// Latency : n/a (package; gate_eval is purely combinational).
// Backpr. : n/a.
package gate_array_pkg;

  localparam logic [2:0] MODE_AND  = 3'd0;
  localparam logic [2:0] MODE_NAND = 3'd1;
  localparam logic [2:0] MODE_OR   = 3'd2;
  localparam logic [2:0] MODE_NOR  = 3'd3;
  localparam logic [2:0] MODE_XOR  = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;

  // Widest gate gate_eval can reduce; callers zero-extend their input vector
  // to this width and pass the real input count.
  localparam int GATE_MAX_INPUTS = 32;

  // Evaluate one gate over the low n_inputs bits of vec. Reserved modes 6/7
  // fall through to AND.
  function automatic logic gate_eval(input logic [2:0]                 mode,
                                     input logic [GATE_MAX_INPUTS-1:0] vec,
                                     input int                         n_inputs);
    logic v_and;
    logic v_or;
    logic v_xor;
    logic res;
    v_and = 1'b1;
    v_or  = 1'b0;
    v_xor = 1'b0;
    for (int k = 0; k < GATE_MAX_INPUTS; k++) begin
      if (k < n_inputs) begin
        v_and = v_and & vec[k];
        v_or  = v_or  | vec[k];
        v_xor = v_xor ^ vec[k];
      end
    end
    case (mode)
      MODE_NAND: res = ~v_and;
      MODE_OR:   res = v_or;
      MODE_NOR:  res = ~v_or;
      MODE_XOR:  res = v_xor;
      MODE_XNOR: res = ~v_xor;
      default:   res = v_and;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gate_delay_channel.sv
// Purpose : one gate channel: evaluate f, delay it (transport shift register, or an
//           inertial filter when GATE_ARRAY_INERTIAL_EN is defined), flag output changes.
// Latency : f sampled at edge t reaches o_y after edge t+DELAY_CYCLES-1.
// Backpr. : none; a new sample is taken every clock.
// Ports   : clk, reset_n (async active-low); i_mode/i_a gate function and inputs;
//           i_valid_nxt = y_valid will be high after this edge; o_y delayed output;
//           o_edge_pulse one-cycle flag in the cycle o_y takes a new value.
module gate_delay_channel
  import gate_array_pkg::*;
#(
  parameter int INPUTS       = 4,
  parameter int DELAY_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        i_mode,
  input  logic [INPUTS-1:0] i_a,
  input  logic              i_valid_nxt,
  output logic              o_y,
  output logic              o_edge_pulse
);

  logic w_f;
  logic w_y_cur;
  logic w_y_nxt;
  logic r_edge;

  assign w_f = gate_eval(i_mode, GATE_MAX_INPUTS'(i_a), INPUTS);

`ifdef GATE_ARRAY_INERTIAL_EN
  localparam int CW = $clog2(DELAY_CYCLES) + 1;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_y;

  // The counter measures how many consecutive edges f has disagreed with y;
  // any agreement restarts it, so only a level held DELAY_CYCLES edges lands.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_y_nxt   = r_y;
    if (w_f == r_y) begin
      w_cnt_nxt = '0;
    end else if (r_cnt == CW'(DELAY_CYCLES - 1)) begin
      w_y_nxt   = w_f;
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_y   <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_y   <= w_y_nxt;
    end
  end

  assign w_y_cur = r_y;
`else
  logic [DELAY_CYCLES-1:0] r_stage;
  logic [DELAY_CYCLES-1:0] w_stage_nxt;

  always_comb begin
    w_stage_nxt    = '0;
    w_stage_nxt[0] = w_f;
    for (int k = 1; k < DELAY_CYCLES; k++) begin
      w_stage_nxt[k] = r_stage[k-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stage <= '0;
    end else begin
      r_stage <= w_stage_nxt;
    end
  end

  assign w_y_cur = r_stage[DELAY_CYCLES-1];
  assign w_y_nxt = w_stage_nxt[DELAY_CYCLES-1];
`endif

  // Computed from the next y value so the pulse lands in the same cycle as the change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge <= 1'b0;
    end else begin
      r_edge <= (w_y_nxt != w_y_cur) & i_valid_nxt;
    end
  end

  assign o_y          = w_y_cur;
  assign o_edge_pulse = r_edge;

endmodule

// File: rtl/gate_array_delayed.sv
// Purpose : CHANNELS independent INPUTS-input gates with run-time mode and a clocked
//           propagation delay; inertial filtering when GATE_ARRAY_INERTIAL_EN is defined.
// Latency : a/mode sampled at edge t appear on y after edge t+DELAY_CYCLES-1.
// Backpr. : none; inputs are sampled every clock.
// Ports   : clk, reset_n (async active-low); mode[2:0] 0 AND,1 NAND,2 OR,3 NOR,4 XOR,
//           5 XNOR, 6/7 AND; a channel i = a[i*INPUTS +: INPUTS]; y delayed outputs;
//           y_valid high from the DELAY_CYCLES-th edge after reset; edge_pulse per channel.
module gate_array_delayed
  import gate_array_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int INPUTS       = 4,
  parameter int DELAY_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [2:0]                 mode,
  input  logic [CHANNELS*INPUTS-1:0] a,
  output logic [CHANNELS-1:0]        y,
  output logic                       y_valid,
  output logic [CHANNELS-1:0]        edge_pulse
);

  localparam int VW = $clog2(DELAY_CYCLES + 1);

  logic [VW-1:0] r_vcnt;
  logic [VW-1:0] w_vcnt_nxt;
  logic          w_valid_nxt;

  // Saturating count of edges since reset release.
  always_comb begin
    w_vcnt_nxt = r_vcnt;
    if (r_vcnt != VW'(DELAY_CYCLES)) begin
      w_vcnt_nxt = r_vcnt + VW'(1);
    end
  end

  assign w_valid_nxt = (w_vcnt_nxt == VW'(DELAY_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vcnt <= '0;
    end else begin
      r_vcnt <= w_vcnt_nxt;
    end
  end

  assign y_valid = (r_vcnt == VW'(DELAY_CYCLES));

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    gate_delay_channel #(
      .INPUTS       (INPUTS),
      .DELAY_CYCLES (DELAY_CYCLES)
    ) u_chan (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_mode       (mode),
      .i_a          (a[gi*INPUTS +: INPUTS]),
      .i_valid_nxt  (w_valid_nxt),
      .o_y          (y[gi]),
      .o_edge_pulse (edge_pulse[gi])
    );
  end

endmodule

// File: tb/tb_gate_array_delayed.sv
// Purpose : self-checking bench for gate_array_delayed (2 channels x 4 inputs, 3-cycle delay).
// Latency : driver pushes the hand-computed f for each sampling edge; monitor derives y.
// Backpr. : none.
module tb_gate_array_delayed;

  localparam int CH = 2;
  localparam int IN = 4;
  localparam int D  = 3;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [2:0]     mode;
  logic [CH*IN-1:0] a;
  logic [CH-1:0]  y;
  logic           y_valid;
  logic [CH-1:0]  edge_pulse;

  gate_array_delayed #(
    .CHANNELS     (CH),
    .INPUTS       (IN),
    .DELAY_CYCLES (D)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mode       (mode),
    .a          (a),
    .y          (y),
    .y_valid    (y_valid),
    .edge_pulse (edge_pulse)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // Hand-computed gate results, one entry per sampling edge with reset released.
  logic [CH-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one vector for n consecutive edges (also releases reset).
  task automatic step(input logic [7:0] va, input logic [2:0] vm, input logic [1:0] vf, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset_n = 1'b1;
      a       = va;
      mode    = vm;
      exp_q.push_back(vf);
    end
  endtask

  // Assert reset between edges and confirm outputs clear without a clock edge.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_y", 32'(y), 0);
    chk("async_rst_edge_pulse", 32'(edge_pulse), 0);
    chk("async_rst_y_valid", 32'(y_valid), 0);
  endtask

  // Monitor: after each edge, derive expected y/y_valid/edge_pulse from the
  // last D post-reset samples and compare.
  initial begin : monitor
    logic [CH-1:0] hist[$];
    logic [CH-1:0] ey;
    logic [CH-1:0] py;
    logic [CH-1:0] f;
    logic          rst_at_edge;
    logic          stable;
    int            ns;
    ey = '0;
    py = '0;
    ns = 0;
    forever begin
      @(posedge clk);
      rst_at_edge = reset_n;
      #1;
      if (!rst_at_edge) begin
        exp_q.delete();
        hist.delete();
        ey = '0;
        py = '0;
        ns = 0;
        chk("y_in_reset", 32'(y), 0);
        chk("y_valid_in_reset", 32'(y_valid), 0);
      end else begin
        chk("sb_queue_depth", 32'(exp_q.size()), 1);
        if (exp_q.size() != 0) begin
          f = exp_q.pop_front();
          hist.push_back(f);
          if (hist.size() > D) void'(hist.pop_front());
          if (ns < D) ns++;
          py = ey;
          if (hist.size() == D) begin
`ifdef GATE_ARRAY_INERTIAL_EN
            for (int c = 0; c < CH; c++) begin
              stable = 1'b1;
              for (int k = 1; k < D; k++) begin
                if (hist[k][c] != hist[0][c]) stable = 1'b0;
              end
              if (stable) ey[c] = hist[0][c];
            end
`else
            ey = hist[0];
`endif
          end
          chk("y", 32'(y), 32'(ey));
          chk("y_valid", 32'(y_valid), 32'(ns == D));
          chk("edge_pulse", 32'(edge_pulse), (ns == D) ? 32'(ey ^ py) : 32'd0);
        end
      end
    end
  end

  initial begin : driver
    reset_n = 1'b1;
    a       = '0;
    mode    = '0;
    #1;
    reset_n = 1'b0;
    #2;
    chk("reset_y", 32'(y), 0);
    chk("reset_edge_pulse", 32'(edge_pulse), 0);
    chk("reset_y_valid", 32'(y_valid), 0);

    // AND: all ones, then channel 1 loses its MSB.
    step(8'h00, 3'd0, 2'b00, 5);
    step(8'hFF, 3'd0, 2'b11, 5);
    step(8'h7F, 3'd0, 2'b01, 5);

    // Mode sweep: ch1 = 1111, ch0 = 0110.
    step(8'hF6, 3'd0, 2'b10, 4);
    step(8'hF6, 3'd1, 2'b01, 4);
    step(8'hF6, 3'd2, 2'b11, 4);
    step(8'hF6, 3'd3, 2'b00, 4);
    step(8'hF6, 3'd4, 2'b00, 4);
    step(8'hF6, 3'd5, 2'b11, 4);
    step(8'hF6, 3'd6, 2'b10, 4);
    step(8'hF6, 3'd7, 2'b10, 4);

    // Odd-parity inputs (ch1 = 0001, ch0 = 0111) and all-zero / all-one cases.
    step(8'h17, 3'd4, 2'b11, 4);
    step(8'h17, 3'd5, 2'b00, 4);
    step(8'h17, 3'd2, 2'b11, 4);
    step(8'h00, 3'd3, 2'b11, 4);
    step(8'h00, 3'd1, 2'b11, 4);
    step(8'hFF, 3'd1, 2'b00, 4);

    // Pulses of 1, 2 and 3 cycles on channel 0 in AND mode.
    step(8'h00, 3'd0, 2'b00, 4);
    step(8'h0F, 3'd0, 2'b01, 1);
    step(8'h00, 3'd0, 2'b00, 5);
    step(8'h0F, 3'd0, 2'b01, 2);
    step(8'h00, 3'd0, 2'b00, 5);
    step(8'h0F, 3'd0, 2'b01, 3);
    step(8'h00, 3'd0, 2'b00, 5);

    // Both channels toggling every cycle.
    for (int i = 0; i < 3; i++) begin
      step(8'hFF, 3'd0, 2'b11, 1);
      step(8'h00, 3'd0, 2'b00, 1);
    end
    step(8'h00, 3'd0, 2'b00, 4);

    // Reset with a pulse in flight; it must never emerge afterwards.
    step(8'hFF, 3'd0, 2'b11, 5);
    step(8'h00, 3'd0, 2'b00, 1);
    step(8'h0F, 3'd0, 2'b01, 1);
    mid_reset();
    step(8'h00, 3'd0, 2'b00, 8);
    step(8'hFF, 3'd0, 2'b11, 5);

    // Drain.
    step(8'h00, 3'd0, 2'b00, D + 2);
    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
